midi_tx_framer: RTL
===================

# midi_tx_framer

Serial MIDI output stage that sits directly downstream of the Wishbone MIDI peripheral. It takes one MIDI message, given as a status byte and up to two data bytes, and emits it on a single 31 250-baud line in standard MIDI serial framing. It derives the message length from the status byte and applies MIDI running status. The host sees only a send pulse and busy/done/err flags.

## Interface
- `clk_freq`, default 100000000, system clock frequency in Hz.
- `baud`, default 31250, line bit rate. Bit period `DIV = clk_freq/baud` (integer division, must be ≥ 2).
- `running_status`, default 1. When 1, a repeated channel status byte is omitted.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `status`  in  8  MIDI status byte.
- `data1`  in  8  first data byte.
- `data2`  in  8  second data byte.
- `send`  in  1  one-cycle request; sampled only when `busy`=0.
- `busy`  out  1  message in progress.
- `done`  out  1  one-cycle pulse when the last stop bit completes.
- `err`  out  1  one-cycle pulse when `send` carries an invalid status.
- `midi_txd`  out  1  serial line; idle high.

## Operation
- **Reset values:** `midi_txd`=1, `busy`=0, `done`=0, `err`=0; state IDLE; stored last-status cleared to 0x00 (none).
- **Accept:** on a clock edge with `send`=1 and `busy`=0, latch `status`, `data1` & 0x7F and `data2` & 0x7F. Data bit 7 is always forced to 0.
- **Invalid status:** `status` < 0x80 produces no transmission; `err`=1 for one cycle; `busy` stays 0.
- **Length N from status:**
  - 0x80–0xBF and 0xE0–0xEF: N=3.
  - 0xC0–0xDF: N=2.
  - 0xF2: N=3.
  - 0xF1 and 0xF3: N=2.
  - All other 0xF0–0xFF: N=1.
- **Running status** (when `running_status`=1):
  - If status is in 0x80–0xEF and equals the stored last-status, the status byte is skipped and N−1 bytes are sent.
  - Any status in 0x80–0xEF updates last-status when it is accepted.
  - Any status in 0xF0–0xF7 clears last-status.
  - Real-time statuses 0xF8–0xFF leave last-status unchanged.
- **Byte sequence:** status (unless skipped), then data1, then data2, truncated to N bytes.
- **Frame format:** start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIV cycles.
- **FSM states:** IDLE, START, BITS, STOP.
  - IDLE → START on a valid accept.
  - START → BITS after DIV cycles.
  - BITS → STOP after 8 bits.
  - STOP → START if more bytes remain, else → IDLE.
- **Counters:**
  - Baud counter runs 0..DIV−1 and reloads at 0 on every state entry.
  - Bit index runs 0..7.
  - Byte index runs 0..2.
- **Ignored requests:** `send` while `busy`=1 is ignored. No queueing, no `err`.

## Timing
- **Accept edge:** `busy`=1 and `midi_txd`=0 (start bit) in the first cycle after the accept edge. Zero idle gap.
- **Inter-byte spacing:** bytes are back-to-back. The start bit of byte k+1 follows the last stop-bit cycle of byte k immediately.
- **Message duration:** `busy` is high for exactly M·10·DIV cycles, where M is the number of bytes actually sent.
- **Completion:** in the cycle after the final stop-bit cycle, `busy`=0, `done`=1 for one cycle, and `midi_txd`=1.
- **Back-to-back messages:** `send` asserted in the same cycle `done` is high is accepted. The next start bit begins one cycle later.
- **`err` timing:** `err` is asserted in the cycle after the rejected `send` edge.
- **Reset mid-operation:** all outputs return to reset values on the next edge. The partial frame is abandoned and last-status is cleared.
- **Output glitches:** `midi_txd` is driven from a register and is glitch-free.

## Test plan
All scenarios use `clk_freq`=312500 and `baud`=31250, giving DIV=10.
1. **Note-on, 3 bytes:** send status 0x90, data1 0x3C, data2 0x64 → line decodes 0x90, 0x3C, 0x64; `busy` high exactly 300 cycles; single `done` pulse.
2. **Running status and program change:**
   - Follow scenario 1 with 0x90/0x40/0x00 → only 0x40, 0x00 sent (200 cycles).
   - Then 0xC5/0x07/0x55 → 0xC5, 0x07 sent (200 cycles).
3. **Real-time and system status:**
   - After 0x90 is stored, send 0xF8 → one byte 0xF8 (100 cycles).
   - Then 0x90/0x10/0x20 → 2 bytes (status still stored).
   - Then 0xF1/0x22 → 0xF1, 0x22 sent, last-status cleared.
   - Then 0x90/0x10/0x20 → 3 bytes.
4. **Invalid status and data masking:**
   - Status 0x45 → `err` one cycle, `midi_txd` stays 1, `busy` stays 0.
   - Status 0xB0, data1 0xFF, data2 0x80 → bytes 0xB0, 0x7F, 0x00.
5. **Busy drop and reset:**
   - `send` with 0x80 during cycle 50 of a busy message → ignored; the original message completes unchanged.
   - `rst` asserted in cycle 137 → next cycle `midi_txd`=1, `busy`=0.
   - Then 0x90/0x01/0x02 → 3 bytes sent.
6. **Back-to-back with running_status=0:**
   - `send` pulsed in the `done` cycle → next start bit exactly 1 cycle later.
   - Two identical 0x90 messages → 3 + 3 bytes sent.

Source files
------------

// File: rtl/midi_tx_framer.sv
// midi_tx_framer: frames one MIDI message (status + up to two data bytes) onto a serial line, with running status
module midi_tx_framer #(
   parameter int clk_freq = 100000000,
   parameter int baud = 31250,
   parameter bit running_status = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] status,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       midi_txd
);
   localparam int DIV = clk_freq / baud;
   localparam int CW = $clog2(DIV);
   typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_n;
   logic [1:0] byte_idx, byte_n, len, len_n, slen;
   logic [2:0][7:0] msg, msg_n;
   logic [7:0] last_st, last_n;
   logic accept, skip, tick, txd_n, done_n, err_n;
   assign tick = cnt == CW'(DIV - 1);
   assign busy = state != IDLE;
   always_comb begin
      accept = state == IDLE && send && status[7];
      slen = status inside {[8'hC0:8'hDF], 8'hF1, 8'hF3} ? 2'd2 :
             (status[7:4] == 4'hF && status != 8'hF2) ? 2'd1 : 2'd3;
      skip = running_status && status[7:4] != 4'hF && status == last_st;
      state_n = state;
      cnt_n = (state == IDLE || tick) ? '0 : cnt + CW'(1);
      bit_n = bit_idx;
      byte_n = byte_idx;
      len_n = len;
      msg_n = msg;
      last_n = last_st;
      case (state)
         IDLE: if (accept) begin
            state_n = START;
            msg_n = {{1'b0, data2[6:0]}, {1'b0, data1[6:0]}, status};
            byte_n = {1'b0, skip};
            len_n = slen;
            // real-time bytes (0xF8..0xFF) must not disturb the stored channel status
            last_n = status[7:4] != 4'hF ? status : status[3] ? last_st : 8'h00;
         end
         START: if (tick) begin
            state_n = BITS;
            bit_n = '0;
         end
         BITS: if (tick) begin
            bit_n = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : BITS;
         end
         STOP: if (tick) begin
            state_n = byte_idx + 2'd1 < len ? START : IDLE;
            byte_n = byte_idx + 2'd1 < len ? byte_idx + 2'd1 : byte_idx;
         end
         default: state_n = IDLE;
      endcase
      txd_n = state_n == START ? 1'b0 : state_n == BITS ? msg_n[byte_n][bit_n] : 1'b1;
      done_n = state == STOP && tick && state_n == IDLE;
      err_n = state == IDLE && send && !status[7];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         byte_idx <= '0;
         len <= '0;
         msg <= '0;
         last_st <= 8'h00;
         midi_txd <= 1'b1;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         byte_idx <= byte_n;
         len <= len_n;
         msg <= msg_n;
         last_st <= last_n;
         midi_txd <= txd_n;
         done <= done_n;
         err <= err_n;
      end
   end
endmodule
